// File: rtl/room_temp_model_if.sv
// Signal bundle between the room thermal plant and the air-conditioning
// controller (or a bench standing in for it).
interface room_temp_model_if;
  logic       heating;
  logic       cooling;
  logic       load;
  logic [4:0] load_temp;
  logic [4:0] temperature;
  logic       changed;
  logic       fault;

  modport master (
    output heating,
    output cooling,
    output load,
    output load_temp,
    input  temperature,
    input  changed,
    input  fault
  );

  modport slave (
    input  heating,
    input  cooling,
    input  load,
    input  load_temp,
    output temperature,
    output changed,
    output fault
  );
endinterface

// File: rtl/room_temp_model.sv
// Room thermal plant: temperature steps up under heating, down under cooling,
// and drifts toward an ambient value when neither actuator is on.
module room_temp_model #(
  parameter int INIT_TEMP    = 18,
  parameter int AMBIENT      = 15,
  parameter int STEP_PERIOD  = 4,
  parameter int DRIFT_PERIOD = 8
) (
  input logic               clk,
  input logic               rst_n,
  room_temp_model_if.slave  bus
);

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'd0,
    MODE_HEAT  = 3'd1,
    MODE_COOL  = 3'd2,
    MODE_DRIFT = 3'd3,
    MODE_FAULT = 3'd4
  } mode_t;

  localparam int MAX_PERIOD = (STEP_PERIOD > DRIFT_PERIOD) ? STEP_PERIOD : DRIFT_PERIOD;
  localparam int CNT_W      = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;

  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_PERIOD - 1);
  localparam logic [CNT_W-1:0] DRIFT_LAST  = CNT_W'(DRIFT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [4:0]       INIT_VAL    = 5'(INIT_TEMP);
  localparam logic [4:0]       AMBIENT_VAL = 5'(AMBIENT);

  function automatic logic [4:0] heat_step(input logic [4:0] t);
    return (t == 5'd31) ? t : t + 5'd1;
  endfunction

  function automatic logic [4:0] cool_step(input logic [4:0] t);
    return (t == 5'd0) ? t : t - 5'd1;
  endfunction

  function automatic logic [4:0] drift_step(input logic [4:0] t, input logic [4:0] amb);
    logic [4:0] res;
    if (t < amb) begin
      res = t + 5'd1;
    end else if (t > amb) begin
      res = t - 5'd1;
    end else begin
      res = t;
    end
    return res;
  endfunction

  mode_t            r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_temp;
  logic             r_changed;
  logic             r_fault;

  mode_t            w_mode;
  logic [CNT_W-1:0] w_last;
  logic [4:0]       w_step_temp;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [4:0]       w_temp_nxt;
  logic             w_changed_nxt;
  logic             w_fault_nxt;

  // Decode the actuator inputs into the current mode.
  always_comb begin
    w_mode = MODE_DRIFT;
    case ({bus.heating, bus.cooling})
      2'b10:   w_mode = MODE_HEAT;
      2'b01:   w_mode = MODE_COOL;
      2'b00:   w_mode = MODE_DRIFT;
      2'b11:   w_mode = MODE_FAULT;
      default: w_mode = MODE_DRIFT;
    endcase
  end

  // Pick the step period and the candidate stepped temperature for this mode.
  always_comb begin
    w_last      = DRIFT_LAST;
    w_step_temp = r_temp;
    case (w_mode)
      MODE_HEAT: begin
        w_last      = STEP_LAST;
        w_step_temp = heat_step(r_temp);
      end
      MODE_COOL: begin
        w_last      = STEP_LAST;
        w_step_temp = cool_step(r_temp);
      end
      MODE_DRIFT: begin
        w_last      = DRIFT_LAST;
        w_step_temp = drift_step(r_temp, AMBIENT_VAL);
      end
      default: begin
        w_last      = DRIFT_LAST;
        w_step_temp = r_temp;
      end
    endcase
  end

  // Next-state logic: load beats mode change, which beats the step counter.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_temp_nxt = r_temp;
    if (bus.load) begin
      w_cnt_nxt  = CNT_ZERO;
      w_temp_nxt = bus.load_temp;
    end else if (w_mode != r_mode) begin
      // A mode change only restarts the period; no step on this edge.
      w_cnt_nxt = CNT_ZERO;
    end else if (w_mode == MODE_FAULT) begin
      w_cnt_nxt = CNT_ZERO;
    end else if (r_cnt == w_last) begin
      w_cnt_nxt  = CNT_ZERO;
      w_temp_nxt = w_step_temp;
    end else begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end
    w_changed_nxt = (w_temp_nxt != r_temp);
    w_fault_nxt   = (w_mode == MODE_FAULT);
  end

  // Mode register (the previous cycle's decoded mode).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_IDLE;
    end else begin
      r_mode <= w_mode;
    end
  end

  // Step counter, temperature and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= CNT_ZERO;
      r_temp    <= INIT_VAL;
      r_changed <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_temp    <= w_temp_nxt;
      r_changed <= w_changed_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  assign bus.temperature = r_temp;
  assign bus.changed     = r_changed;
  assign bus.fault       = r_fault;

endmodule

// File: tb/tb_room_temp_model.sv
// Directed bench for room_temp_model: stepping latency, saturation, drift,
// fault handling, load override, reset abort and a closed-loop run.
module tb_room_temp_model;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  room_temp_model_if bus ();

  room_temp_model #(
    .INIT_TEMP    (18),
    .AMBIENT      (15),
    .STEP_PERIOD  (4),
    .DRIFT_PERIOD (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic h, input logic c);
    bus.heating = h;
    bus.cooling = c;
  endtask

  task automatic do_load(input logic [4:0] val, input logic exp_changed, input logic exp_fault);
    bus.load      = 1'b1;
    bus.load_temp = val;
    step_edge();
    check_eq("load_temp", bus.temperature, val);
    check_eq("load_changed", bus.changed, exp_changed);
    check_eq("load_fault", bus.fault, exp_fault);
    bus.load = 1'b0;
  endtask

  int         exp_t;
  logic       exp_c;
  logic       ctrl_heat;
  int         t_min;
  int         t_max;
  logic       fault_seen;
  logic       both_seen;
  int         n_changes;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.heating   = 1'b0;
    bus.cooling   = 1'b0;
    bus.load      = 1'b0;
    bus.load_temp = 5'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_temp", bus.temperature, 32'd18);
    check_eq("rst_changed", bus.changed, 32'd0);
    check_eq("rst_fault", bus.fault, 32'd0);

    // Heating from reset: steps at edges 5, 9, 13, 17
    drive(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step_edge();
      exp_t = 18 + int'(e >= 5) + int'(e >= 9) + int'(e >= 13) + int'(e >= 17);
      exp_c = (e == 5) || (e == 9) || (e == 13) || (e == 17);
      check_eq("heat_temp", bus.temperature, exp_t);
      check_eq("heat_changed", bus.changed, exp_c);
    end

    // Saturation at 31 under heating
    do_load(5'd31, 1'b1, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      step_edge();
      check_eq("sat_hi_temp", bus.temperature, 32'd31);
      check_eq("sat_hi_changed", bus.changed, 32'd0);
    end

    // Saturation at 0 under cooling, then drift upward
    drive(1'b0, 1'b1);
    do_load(5'd0, 1'b1, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      step_edge();
      check_eq("sat_lo_temp", bus.temperature, 32'd0);
      check_eq("sat_lo_changed", bus.changed, 32'd0);
    end
    drive(1'b0, 1'b0);
    for (int e = 1; e <= 17; e++) begin
      step_edge();
      exp_t = int'(e >= 9) + int'(e >= 17);
      exp_c = (e == 9) || (e == 17);
      check_eq("drift_up_temp", bus.temperature, exp_t);
      check_eq("drift_up_changed", bus.changed, exp_c);
    end

    // Drift down from 20 to ambient 15, then hold
    do_load(5'd20, 1'b1, 1'b0);
    for (int e = 1; e <= 56; e++) begin
      step_edge();
      exp_t = 20 - ((e / 8) > 5 ? 5 : (e / 8));
      exp_c = ((e % 8) == 0) && (e <= 40);
      check_eq("drift_dn_temp", bus.temperature, exp_t);
      check_eq("drift_dn_changed", bus.changed, exp_c);
    end

    // Fault: both actuators on holds temperature; fault flagged from next edge
    do_load(5'd20, 1'b1, 1'b0);
    drive(1'b1, 1'b1);
    for (int e = 1; e <= 10; e++) begin
      step_edge();
      check_eq("fault_flag", bus.fault, 32'd1);
      check_eq("fault_temp", bus.temperature, 32'd20);
      check_eq("fault_changed", bus.changed, 32'd0);
    end
    drive(1'b1, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      step_edge();
      check_eq("unfault_flag", bus.fault, 32'd0);
      check_eq("unfault_temp", bus.temperature, (e >= 5) ? 32'd21 : 32'd20);
    end

    // Load while in fault still reports fault
    drive(1'b1, 1'b1);
    do_load(5'd10, 1'b1, 1'b1);
    step_edge();
    check_eq("load_fault_hold", bus.temperature, 32'd10);

    // Asynchronous reset mid-step, then behaviour as at power-up
    drive(1'b1, 1'b0);
    step_edge();
    step_edge();
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_temp", bus.temperature, 32'd18);
    check_eq("async_rst_changed", bus.changed, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step_edge();
      check_eq("post_rst_temp", bus.temperature, (e >= 5) ? 32'd19 : 32'd18);
    end

    // Closed loop with a hysteresis controller, starting from reset at 18
    rst_n = 1'b0;
    @(negedge clk);
    ctrl_heat  = 1'b1;
    t_min      = 31;
    t_max      = 0;
    fault_seen = 1'b0;
    both_seen  = 1'b0;
    n_changes  = 0;
    drive(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 500; c++) begin
      step_edge();
      if (int'(bus.temperature) < t_min) t_min = int'(bus.temperature);
      if (int'(bus.temperature) > t_max) t_max = int'(bus.temperature);
      if (bus.fault) fault_seen = 1'b1;
      if (bus.changed) n_changes++;
      if (ctrl_heat && bus.temperature >= 5'd22) ctrl_heat = 1'b0;
      else if (!ctrl_heat && bus.temperature <= 5'd18) ctrl_heat = 1'b1;
      drive(ctrl_heat, !ctrl_heat);
      if (bus.heating && bus.cooling) both_seen = 1'b1;
    end
    check_eq("loop_min", t_min, 32'd18);
    check_eq("loop_max", t_max, 32'd22);
    check_eq("loop_fault", fault_seen, 32'd0);
    check_eq("loop_both", both_seen, 32'd0);
    check_eq("loop_moving", n_changes > 50, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
